// File: rtl/psum_collector_pkg.sv
// rtl/psum_collector_pkg.sv - shared psum collector constants and pointer sizing
package psum_collector_pkg;

    // Defaults shared with the systolic array that feeds the collector
    localparam int default_col     = 8;
    localparam int default_psum_bw = 16;
    localparam int default_depth   = 8;

    // Pointer width for a power-of-two FIFO; counts use one extra bit so
    // that "full" (count == depth) is representable.
    function automatic int ptr_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// rtl/psum_col_fifo.sv - single-column first-word-fall-through psum FIFO
module psum_col_fifo
    import psum_collector_pkg::*;
#(
    parameter  int psum_bw = default_psum_bw,
    parameter  int depth   = default_depth,
    localparam int ptr_w   = ptr_width(depth),
    localparam int cnt_w   = ptr_w + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               pop,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout,
    output logic [cnt_w-1:0]   count
);

    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [ptr_w-1:0]   wptr;
    logic [ptr_w-1:0]   rptr;
    logic               accept;

    // A full FIFO still accepts a write when the row pop frees a slot this cycle;
    // the pop is only ever issued while this FIFO is non-empty.
    assign accept = wr && ((count != full_cnt) || pop);

    // Storage is written only; it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally at depth; count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                wptr <= wptr + ptr_w'(1);
            end
            if (pop) begin
                rptr <= rptr + ptr_w'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - re-aligns staggered column psums into complete rows
module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int col     = default_col,
    parameter int psum_bw = default_psum_bw,
    parameter int depth   = default_depth
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_overflow
);

    localparam int cnt_w = ptr_width(depth) + 1;

    logic [cnt_w-1:0]       count [col];
    logic [col-1:0]         nonempty;
    logic [col-1:0]         full;
    logic [col-1:0]         drop;
    logic [psum_bw*col-1:0] heads;
    logic                   pop;

    genvar g;
    generate
        for (g = 0; g < col; g++) begin : g_col
            psum_col_fifo #(
                .psum_bw (psum_bw),
                .depth   (depth)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .wr    (wr[g]),
                .pop   (pop),
                .din   (in[psum_bw*g +: psum_bw]),
                .dout  (heads[psum_bw*g +: psum_bw]),
                .count (count[g])
            );

            assign nonempty[g] = (count[g] != '0);
            assign full[g]     = (count[g] == cnt_w'(depth));
            assign drop[g]     = wr[g] & full[g] & ~pop;
        end
    endgenerate

    // A row is complete only when every column holds at least one psum.
    assign o_valid = &nonempty;
    assign o_full  = |full;
    assign pop     = rd & o_valid;
    assign out     = o_valid ? heads : '0;

    // Sticky record that some column lost a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_overflow <= 1'b0;
        end else if (|drop) begin
            o_overflow <= 1'b1;
        end
    end

endmodule
